pattern_scan_ctrl: RTL
======================

PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, giving the match counter width in bits.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-004 SHALL have port start, input, 1 bit: begin a frame scan; sampled only in IDLE.
REQ-005 SHALL have port pattern, input, 4 bits: target pattern, bit 3 oldest; latched on accepted start.
REQ-006 SHALL have port frame_len, input, 8 bits: number of bytes in the frame; latched on accepted start.
REQ-007 SHALL have port byte_data, input, 8 bits: byte to scan, serialized MSB first.
REQ-008 SHALL have port byte_valid, input, 1 bit: byte_data is valid.
REQ-009 SHALL have port byte_ready, output, 1 bit: controller accepts a byte this cycle.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse at end of frame.
REQ-012 SHALL have port match_pulse, output, 1 bit: registered one-cycle flag per detected match.
REQ-013 SHALL have port match_count, output, CNT_W bits: matches counted in the current or last frame.
REQ-014 SHALL have port overflow, output, 1 bit: sticky flag, match_count saturated.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, SHIFT and DONE; all outputs SHALL be registered except byte_ready and busy, which are decoded from state.
REQ-016 In IDLE with start=1, SHALL latch pattern and frame_len and clear match_count, overflow, the 4-bit history register and the history fill counter, then go to LOAD, or to DONE if frame_len==0.
REQ-017 start SHALL be ignored in every state other than IDLE.
REQ-018 In LOAD, byte_ready SHALL be 1; byte_valid&&byte_ready SHALL load byte_data into the shift register, set bit index to 7 and go to SHIFT; byte_valid without ready SHALL be ignored.
REQ-019 In SHIFT, SHALL consume one bit per cycle, MSB first: history <= {history[2:0], bit}; fill counter saturates at 4.
REQ-020 A match SHALL be flagged when the fill counter already holds 3 or more and {history[2:0], bit}==latched pattern; overlapping matches SHALL count, including windows spanning byte boundaries.
REQ-021 On a match, match_pulse SHALL be 1 for exactly the next cycle and match_count SHALL increment at the same edge.
REQ-022 match_count SHALL saturate at 2^CNT_W-1; a match at saturation SHALL set overflow, which holds until the next accepted start or reset.
REQ-023 After the bit-index-0 cycle, SHALL decrement bytes remaining and go to LOAD if bytes remain, else to DONE.
REQ-024 Each byte SHALL take exactly 9 cycles: 1 accept cycle plus 8 shift cycles, with no stall once accepted.
REQ-025 In DONE, done SHALL be 1 for one cycle and the FSM SHALL return to IDLE; match_count and overflow SHALL be final when done=1 and hold until the next accepted start.
REQ-026 The history register SHALL persist across bytes within a frame and SHALL NOT carry across frames.

Reset
REQ-027 reset=0 SHALL immediately force IDLE, independent of clk, including mid-frame.
REQ-028 During reset, SHALL hold byte_ready=0, busy=0, done=0, match_pulse=0, match_count=0 and overflow=0.
REQ-029 The history register, fill counter, bit index, byte counter and latched pattern/frame_len SHALL all reset to 0.

Verification
REQ-030 Pattern 4'b1101, frame_len=1, byte 0xD0 -> match_count=1, exactly one match_pulse, done 10 cycles after the byte is accepted.
REQ-031 Pattern 4'b1101, frame_len=2, bytes 0x0D then 0xA0 -> match_count=2; the second match spans the byte boundary.
REQ-032 Pattern 4'b1111, frame_len=1, byte 0xFF -> match_count=5 (overlapping); pattern 4'b0000 with 64 bytes of 0x00 -> match_count=255, overflow=1.
REQ-033 frame_len=0 with start=1 -> done pulses 2 cycles after start, match_count=0, byte_ready never 1.
REQ-034 reset driven low mid-SHIFT -> busy=0, byte_ready=0, match_count=0 before the next clk edge; a new frame after reset releases counts from 0.
REQ-035 start pulsed while busy, and byte_valid held high while not in LOAD -> no effect on the count; exactly frame_len bytes are accepted.

Source files
------------

// File: rtl/pattern_scan_ctrl.sv
// Frame scanner: serializes bytes MSB first into a 4-bit history window and
// counts (overlapping) occurrences of a latched 4-bit pattern per frame.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; last frame's count/overflow held
// S_LOAD  | byte_ready high, waiting for the next byte of the frame
// S_SHIFT | consuming one bit per cycle, bit index 7 down to 0
// S_DONE  | frame finished; done pulses on the following cycle
module pattern_scan_ctrl #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       pattern,
   input  logic [7:0]       frame_len,
   input  logic [7:0]       byte_data,
   input  logic             byte_valid,
   output logic             byte_ready,
   output logic             busy,
   output logic             done,
   output logic             match_pulse,
   output logic [CNT_W-1:0] match_count,
   output logic             overflow
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_q, state_d;
   logic [3:0]       pat_q, pat_d;
   logic [7:0]       len_q, len_d;
   logic [7:0]       shreg_q, shreg_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [3:0]       hist_q, hist_d;
   logic [2:0]       fill_q, fill_d;
   logic             pulse_q, pulse_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;

   logic             bit_in;
   logic [3:0]       window;
   logic             is_match;

   assign bit_in   = shreg_q[bit_idx_q];
   assign window   = {hist_q[2:0], bit_in};
   // fill_q counts bits already in the history, so a full window needs 3 before this bit
   assign is_match = (state_q == S_SHIFT) && (fill_q >= 3'd3) && (window == pat_q);

   always_comb begin
      state_d   = state_q;
      pat_d     = pat_q;
      len_d     = len_q;
      shreg_d   = shreg_q;
      bit_idx_d = bit_idx_q;
      hist_d    = hist_q;
      fill_d    = fill_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      pulse_d   = 1'b0;
      done_d    = (state_q == S_DONE);

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               pat_d   = pattern;
               len_d   = frame_len;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               hist_d  = 4'd0;
               fill_d  = 3'd0;
               state_d = (frame_len == 8'd0) ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: begin
            if (byte_valid) begin
               shreg_d   = byte_data;
               bit_idx_d = 3'd7;
               state_d   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            hist_d    = window;
            bit_idx_d = bit_idx_q - 3'd1;
            if (fill_q != 3'd4) fill_d = fill_q + 3'd1;
            if (is_match) begin
               pulse_d = 1'b1;
               if (cnt_q == CNT_MAX) ovf_d = 1'b1;
               else                  cnt_d = cnt_q + CNT_ONE;
            end
            if (bit_idx_q == 3'd0) begin
               len_d   = len_q - 8'd1;
               state_d = (len_q == 8'd1) ? S_DONE : S_LOAD;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         pat_q     <= 4'd0;
         len_q     <= 8'd0;
         shreg_q   <= 8'd0;
         bit_idx_q <= 3'd0;
         hist_q    <= 4'd0;
         fill_q    <= 3'd0;
         pulse_q   <= 1'b0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pat_q     <= pat_d;
         len_q     <= len_d;
         shreg_q   <= shreg_d;
         bit_idx_q <= bit_idx_d;
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         pulse_q   <= pulse_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
      end
   end

   assign byte_ready  = (state_q == S_LOAD);
   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign match_pulse = pulse_q;
   assign match_count = cnt_q;
   assign overflow    = ovf_q;

endmodule
